// File: rtl/vec_exec_unit.sv
// vec_exec_unit: multi-cycle 16-lane x 16-bit vector execute stage.
// Lanes are processed LANES_PER_CYCLE at a time over NUM_GROUPS RUN cycles
// and the result is written back in a single registered WB cycle.
//
// Handshake: start is sampled only while the unit is idle (busy=0). A start
// seen while busy is dropped. busy rises the cycle after acceptance and falls
// after the single-cycle wr_en strobe. wr_dst and wr_data are meaningful only
// while wr_en=1.
module vec_exec_unit #(
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [2:0]   dst,
    input  logic [255:0] src_a,
    input  logic [255:0] src_b,
    output logic         busy,
    output logic         wr_en,
    output logic [2:0]   wr_dst,
    output logic [255:0] wr_data,
    output logic [1:0]   dbg_state
);

    localparam int NUM_GROUPS = 16 / LANES_PER_CYCLE;
    localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GROUP = GW'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_VADD = 2'd0,
        OP_VSUB = 2'd1,
        OP_VMUL = 2'd2,
        OP_VDOT = 2'd3
    } op_t;

    state_t         state_q;
    op_t            op_q;
    logic [2:0]     dst_q;
    logic [255:0]   a_q;
    logic [255:0]   b_q;
    logic [255:0]   res_q, res_d;
    logic [15:0]    acc_q, acc_d;
    logic [GW-1:0]  group_q;
    logic           busy_q;
    logic           wr_en_q;
    logic [2:0]     wr_dst_q;
    logic [255:0]   wr_data_q;

    logic [15:0]    lane_a, lane_b, lane_r;
    logic [255:0]   wb_data_d;

    // Shared lane datapath: compute the current group's lanes and fold the
    // products into the dot-product accumulator.
    always_comb begin
        res_d  = res_q;
        acc_d  = acc_q;
        lane_a = '0;
        lane_b = '0;
        lane_r = '0;
        for (int l = 0; l < LANES_PER_CYCLE; l++) begin
            lane_a = a_q[(int'(group_q) * LANES_PER_CYCLE + l) * 16 +: 16];
            lane_b = b_q[(int'(group_q) * LANES_PER_CYCLE + l) * 16 +: 16];
            unique case (op_q)
                OP_VADD: lane_r = lane_a + lane_b;
                OP_VSUB: lane_r = lane_a - lane_b;
                default: lane_r = lane_a * lane_b;
            endcase
            res_d[(int'(group_q) * LANES_PER_CYCLE + l) * 16 +: 16] = lane_r;
            if (op_q == OP_VDOT) begin
                acc_d = acc_d + lane_r;
            end
        end
        // Final write-back word includes the group being finished this cycle.
        wb_data_d = (op_q == OP_VDOT) ? {240'd0, acc_d} : res_d;
    end

    // Control FSM with registered outputs; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_VADD;
            dst_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            acc_q     <= '0;
            group_q   <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_dst_q  <= '0;
            wr_data_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    wr_en_q <= 1'b0;
                    if (start) begin
                        op_q    <= op_t'(op);
                        dst_q   <= dst;
                        a_q     <= src_a;
                        b_q     <= src_b;
                        res_q   <= '0;
                        acc_q   <= '0;
                        group_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    acc_q   <= acc_d;
                    group_q <= group_q + GW'(1);
                    if (group_q == LAST_GROUP) begin
                        group_q   <= '0;
                        wr_en_q   <= 1'b1;
                        wr_dst_q  <= dst_q;
                        wr_data_q <= wb_data_d;
                        state_q   <= S_WB;
                    end
                end
                S_WB: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign wr_en     = wr_en_q;
    assign wr_dst    = wr_dst_q;
    assign wr_data   = wr_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed testbench for vec_exec_unit (default LANES_PER_CYCLE=4, so the
// write strobe is expected 5 cycles after the accepting edge).
module tb_vec_exec_unit;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [2:0]   dst;
    logic [255:0] src_a;
    logic [255:0] src_b;
    logic         busy;
    logic         wr_en;
    logic [2:0]   wr_dst;
    logic [255:0] wr_data;
    logic [1:0]   dbg_state;

    int checks;
    int errors;

    vec_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .dst       (dst),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_dst    (wr_dst),
        .wr_data   (wr_data),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] splat(input logic [15:0] v);
        return {16{v}};
    endfunction

    // Present one operation, let the accepting edge pass, then scramble inputs.
    task automatic launch(input logic [1:0] o, input logic [2:0] d,
                          input logic [255:0] a, input logic [255:0] b);
        op    = o;
        dst   = d;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = ~o;
        dst   = ~d;
        src_a = ~a;
        src_b = b ^ {64{4'hA}};
    endtask

    // Watch n cycles after acceptance (cycle k=1 is the first after the edge).
    task automatic observe(input int n, output int cnt, output int at,
                           output logic [255:0] data, output logic [2:0] d,
                           output logic [15:0] bmask);
        cnt   = 0;
        at    = -1;
        data  = '0;
        d     = '0;
        bmask = '0;
        for (int k = 1; k <= n; k++) begin
            bmask[k] = busy;
            if (wr_en === 1'b1) begin
                cnt++;
                at   = k;
                data = wr_data;
                d    = wr_dst;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'd0;
        dst   = 3'd5;
        src_a = splat(16'h0001);
        src_b = splat(16'h0001);
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || wr_en !== 1'b0 || wr_data !== 256'd0 || dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got busy=%b wr_en=%b state=%0d data_nz=%b, expected 0 0 0 0",
                         k, busy, wr_en, dbg_state, (wr_data !== 256'd0));
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || wr_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_dropped_start[%0d]: got busy=%b wr_en=%b, expected 0 0", k, busy, wr_en);
            end
        end
    endtask

    task automatic test_vadd();
        logic [255:0] a, b, e, data;
        logic [2:0]   d;
        logic [15:0]  bmask;
        int           cnt, at;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                a = splat(16'h0001);
                b = splat(16'h0002);
                e = splat(16'h0003);
            end else begin
                for (int i = 0; i < 16; i++) begin
                    a[i*16 +: 16] = 16'(i * 257);
                    b[i*16 +: 16] = 16'h1000;
                    e[i*16 +: 16] = 16'(i * 257 + 16'h1000);
                end
            end
            launch(2'd0, 3'd3, a, b);
            observe(7, cnt, at, data, d, bmask);
            checks++;
            if (cnt != 1 || at != 5) begin
                errors++;
                $display("FAIL vadd%0d_timing: got %0d strobes last at T+%0d, expected 1 at T+5", t, cnt, at);
            end
            checks++;
            if (data !== e || d !== 3'd3) begin
                errors++;
                $display("FAIL vadd%0d_data: got dst=%0d data=%h, expected dst=3 data=%h", t, d, data, e);
            end
            checks++;
            if (bmask !== 16'h003E) begin
                errors++;
                $display("FAIL vadd%0d_busy: got busy mask %h, expected 003e", t, bmask);
            end
            checks++;
            if (wr_data !== e || dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL vadd%0d_hold: got state=%0d data=%h, expected state=0 data=%h", t, dbg_state, wr_data, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0]   ops [3]  = '{2'd0, 2'd1, 2'd2};
        logic [15:0]  va  [3]  = '{16'hFFFF, 16'h0000, 16'h0100};
        logic [15:0]  vb  [3]  = '{16'h0002, 16'h0001, 16'h0100};
        logic [15:0]  ve  [3]  = '{16'h0001, 16'hFFFF, 16'h0000};
        logic [255:0] data;
        logic [2:0]   d;
        logic [15:0]  bmask;
        int           cnt, at;
        for (int t = 0; t < 3; t++) begin
            launch(ops[t], 3'(t + 1), splat(va[t]), splat(vb[t]));
            observe(7, cnt, at, data, d, bmask);
            checks++;
            if (cnt != 1 || at != 5 || d !== 3'(t + 1) || data !== splat(ve[t])) begin
                errors++;
                $display("FAIL wrap%0d: got cnt=%0d at=%0d dst=%0d data=%h, expected 1 5 %0d lanes %h",
                         t, cnt, at, d, data, t + 1, ve[t]);
            end
        end
        // Non-trivial multiply: 3*5 = 15 in every lane.
        launch(2'd2, 3'd4, splat(16'h0003), splat(16'h0005));
        observe(7, cnt, at, data, d, bmask);
        checks++;
        if (cnt != 1 || at != 5 || data !== splat(16'h000F)) begin
            errors++;
            $display("FAIL vmul_small: got cnt=%0d at=%0d data=%h, expected 1 5 lanes 000f", cnt, at, data);
        end
    endtask

    task automatic test_vdot();
        logic [255:0] a, data;
        logic [2:0]   d;
        logic [15:0]  bmask;
        int           cnt, at;
        for (int i = 0; i < 16; i++) a[i*16 +: 16] = 16'(i + 1);
        launch(2'd3, 3'd2, a, splat(16'h0002));
        observe(8, cnt, at, data, d, bmask);
        checks++;
        if (cnt != 1 || at != 5) begin
            errors++;
            $display("FAIL vdot_timing: got %0d strobes at T+%0d, expected 1 at T+5", cnt, at);
        end
        checks++;
        if (data !== {240'd0, 16'h0110} || d !== 3'd2) begin
            errors++;
            $display("FAIL vdot_data: got dst=%0d data=%h, expected dst=2 lane0=0110 others 0", d, data);
        end
    endtask

    task automatic test_back_to_back();
        int           cnt, at1, at2;
        logic [255:0] data1, data2;
        logic [2:0]   d1, d2;
        cnt = 0; at1 = -1; at2 = -1; data1 = '0; data2 = '0; d1 = '0; d2 = '0;
        launch(2'd0, 3'd3, splat(16'h0001), splat(16'h0002));
        for (int k = 1; k <= 14; k++) begin
            if (wr_en === 1'b1) begin
                cnt++;
                if (cnt == 1) begin
                    at1 = k; data1 = wr_data; d1 = wr_dst;
                end else begin
                    at2 = k; data2 = wr_data; d2 = wr_dst;
                end
            end
            if (k == 2) begin
                op = 2'd2; dst = 3'd7; src_a = splat(16'h1234); src_b = splat(16'h5678); start = 1'b1;
            end else if (k == 7) begin
                op = 2'd1; dst = 3'd6; src_a = splat(16'h0005); src_b = splat(16'h0007); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (cnt != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d strobes, expected 2", cnt);
        end
        checks++;
        if (at1 != 5 || d1 !== 3'd3 || data1 !== splat(16'h0003)) begin
            errors++;
            $display("FAIL b2b_first: got at=%0d dst=%0d data=%h, expected 5 3 lanes 0003", at1, d1, data1);
        end
        checks++;
        if (at2 != 12 || d2 !== 3'd6 || data2 !== splat(16'hFFFE)) begin
            errors++;
            $display("FAIL b2b_second: got at=%0d dst=%0d data=%h, expected 12 6 lanes fffe", at2, d2, data2);
        end
    endtask

    task automatic test_reset_mid_op();
        int           cnt, at;
        logic [255:0] data;
        logic [2:0]   d;
        cnt = 0; at = -1; data = '0; d = '0;
        launch(2'd0, 3'd3, splat(16'h0001), splat(16'h0002));
        for (int k = 1; k <= 12; k++) begin
            if (wr_en === 1'b1) begin
                cnt++; at = k; data = wr_data; d = wr_dst;
            end
            if (k == 4) begin
                checks++;
                if (busy !== 1'b0 || wr_data !== 256'd0 || dbg_state !== 2'd0) begin
                    errors++;
                    $display("FAIL midrst_state: got busy=%b state=%0d data=%h, expected 0 0 0", busy, dbg_state, wr_data);
                end
            end
            rst   = (k == 3);
            if (k == 5) begin
                op = 2'd1; dst = 3'd5; src_a = splat(16'h000A); src_b = splat(16'h0003); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if (cnt != 1 || at != 10 || d !== 3'd5 || data !== splat(16'h0007)) begin
            errors++;
            $display("FAIL midrst_restart: got cnt=%0d at=%0d dst=%0d data=%h, expected 1 10 5 lanes 0007",
                     cnt, at, d, data);
        end
    endtask

    // Test sequence and report
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = '0;
        dst    = '0;
        src_a  = '0;
        src_b  = '0;
        test_reset();
        test_vadd();
        test_wrap();
        test_vdot();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
